// File: rtl/vga_pkg.sv
// Shared definitions for the VGA scanout block: default 640x480@60 timing,
// the rgb444 pixel type and the grayscale ramp used as the palette reset image.
package vga_pkg;

  localparam int DEF_H_VIS  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_VIS  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Per-pixel control that travels alongside the memory read.
  // hs/vs are "sync active" flags; polarity is applied at the output register.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic win;
    logic fs;
  } pix_ctl_t;

  function automatic rgb444_t gray_entry(input logic [3:0] i);
    gray_entry.r = i;
    gray_entry.g = i;
    gray_entry.b = i;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raw raster counters and unregistered sync/enable decode for the scanout core.
// Sync flags are active-high here; the consumer applies polarity.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VIS  = DEF_H_VIS,
  parameter int H_FP   = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int V_VIS  = DEF_V_VIS,
  parameter int V_FP   = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP
) (
  input  logic       pclk,
  input  logic       rst,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       hs_act,
  output logic       vs_act,
  output logic       de,
  output logic       frame_first,
  output logic       frame_last
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  logic h_last;
  logic v_last;

  assign h_last = (h == 10'(H_TOT - 1));
  assign v_last = (v == 10'(V_TOT - 1));

  always_ff @(posedge pclk) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (h_last) begin
      h <= '0;
      v <= v_last ? 10'd0 : v + 10'd1;
    end else begin
      h <= h + 10'd1;
    end
  end

  // Offset compare keeps each sync window a single unsigned test.
  assign hs_act      = (h - 10'(H_VIS + H_FP)) < 10'(H_SYNC);
  assign vs_act      = (v - 10'(V_VIS + V_FP)) < 10'(V_SYNC);
  assign de          = (h < 10'(H_VIS)) && (v < 10'(V_VIS));
  assign frame_first = (h == 10'd0) && (v == 10'd0);
  assign frame_last  = h_last && v_last;

endmodule

// File: rtl/vga_scanout_core.sv
// VGA scanout: centred, integer-scaled image fetched from a latency-MEM_LAT memory.
// Optional 16-entry palette enabled by defining VGA_SCANOUT_PALETTE_EN.
module vga_scanout_core
  import vga_pkg::*;
#(
  parameter int H_VIS   = DEF_H_VIS,
  parameter int H_FP    = DEF_H_FP,
  parameter int H_SYNC  = DEF_H_SYNC,
  parameter int H_BP    = DEF_H_BP,
  parameter int V_VIS   = DEF_V_VIS,
  parameter int V_FP    = DEF_V_FP,
  parameter int V_SYNC  = DEF_V_SYNC,
  parameter int V_BP    = DEF_V_BP,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b0,
  parameter int IMG_W   = 224,
  parameter int IMG_H   = 288,
  parameter int SCALE   = 1,
  parameter int MEM_LAT = 1,
  parameter int PIX_W   = 4,
  parameter int ADDR_W  = 16
) (
  input  logic              pclk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_data,
  output logic [9:0]        h,
  output logic [9:0]        v,
  output logic              hs,
  output logic              vs,
  output logic              de,
  output logic [3:0]        r,
  output logic [3:0]        g,
  output logic [3:0]        b,
  output logic              frame_start
`ifdef VGA_SCANOUT_PALETTE_EN
  ,
  input  logic              pal_we,
  input  logic [3:0]        pal_idx,
  input  logic [11:0]       pal_rgb
`endif
);

  localparam int WIN_W = IMG_W * SCALE;
  localparam int WIN_H = IMG_H * SCALE;
  localparam int X0    = (H_VIS - WIN_W) / 2;
  localparam int Y0    = (V_VIS - WIN_H) / 2;
  localparam int X1    = X0 + WIN_W;
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  if (SCALE < 1 || SCALE > 4) begin : g_bad_scale
    $error("vga_scanout_core: SCALE must be 1..4");
  end
  if (MEM_LAT < 1 || MEM_LAT > 3) begin : g_bad_lat
    $error("vga_scanout_core: MEM_LAT must be 1..3");
  end
  if (WIN_W > H_VIS || WIN_H > V_VIS) begin : g_bad_win
    $error("vga_scanout_core: scaled image exceeds visible area");
  end
  if (longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << ADDR_W)) begin : g_bad_addr
    $error("vga_scanout_core: image does not fit ADDR_W");
  end
  if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_tot
    $error("vga_scanout_core: raster exceeds 10-bit counters");
  end

  logic hs_act, vs_act, de_raw, frame_first, frame_last;

  vga_timing_gen #(
    .H_VIS (H_VIS),  .H_FP (H_FP),  .H_SYNC (H_SYNC),  .H_BP (H_BP),
    .V_VIS (V_VIS),  .V_FP (V_FP),  .V_SYNC (V_SYNC),  .V_BP (V_BP)
  ) u_timing (
    .pclk        (pclk),
    .rst         (rst),
    .h           (h),
    .v           (v),
    .hs_act      (hs_act),
    .vs_act      (vs_act),
    .de          (de_raw),
    .frame_first (frame_first),
    .frame_last  (frame_last)
  );

  // Window decode: offset subtraction wraps for positions left/above the window.
  logic in_x, in_y, in_win;
  assign in_x   = ({1'b0, h} - 11'(X0)) < 11'(WIN_W);
  assign in_y   = ({1'b0, v} - 11'(Y0)) < 11'(WIN_H);
  assign in_win = in_x && in_y;

  logic [ADDR_W-1:0] row_base, col, held, cur_addr;
  logic [1:0]        row_sub, col_sub;

  assign cur_addr = row_base + col;
  assign mem_addr = in_win ? cur_addr : held;

  // Address walks incrementally: col_sub/row_sub count SCALE repeats.
  always_ff @(posedge pclk) begin
    if (rst) begin
      row_base <= '0;
      col      <= '0;
      held     <= '0;
      row_sub  <= '0;
      col_sub  <= '0;
    end else begin
      if (in_win) held <= cur_addr;
      if (frame_last) begin
        row_base <= '0;
        col      <= '0;
        row_sub  <= '0;
        col_sub  <= '0;
      end else if (in_win) begin
        if (h == 10'(X1 - 1)) begin
          col     <= '0;
          col_sub <= '0;
          if (row_sub == 2'(SCALE - 1)) begin
            row_sub  <= '0;
            row_base <= row_base + ADDR_W'(IMG_W);
          end else begin
            row_sub <= row_sub + 2'd1;
          end
        end else if (col_sub == 2'(SCALE - 1)) begin
          col_sub <= '0;
          col     <= col + ADDR_W'(1);
        end else begin
          col_sub <= col_sub + 2'd1;
        end
      end
    end
  end

  pix_ctl_t raw;
  pix_ctl_t pipe [MEM_LAT];
  pix_ctl_t tail;

  assign raw  = '{hs: hs_act, vs: vs_act, de: de_raw, win: in_win, fs: frame_first};
  assign tail = pipe[MEM_LAT-1];

  always_ff @(posedge pclk) begin
    if (rst) begin
      for (int i = 0; i < MEM_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= raw;
      for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  rgb444_t pix_rgb;

`ifdef VGA_SCANOUT_PALETTE_EN
  rgb444_t pal [16];

  always_ff @(posedge pclk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) pal[i] <= gray_entry(4'(i));
    end else if (pal_we) begin
      pal[pal_idx] <= rgb444_t'(pal_rgb);
    end
  end

  assign pix_rgb = pal[4'(mem_data)];
`else
  logic [3:0] nib;
  if (PIX_W >= 4) begin : g_nib_wide
    assign nib = mem_data[PIX_W-1 -: 4];
  end else begin : g_nib_narrow
    assign nib = {mem_data, (4 - PIX_W)'(0)};
  end

  assign pix_rgb = gray_entry(nib);
`endif

  // Output register: the extra stage that lines colour up with sync.
  always_ff @(posedge pclk) begin
    if (rst) begin
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      de          <= 1'b0;
      frame_start <= 1'b0;
      {r, g, b}   <= '0;
    end else begin
      hs          <= tail.hs ? HS_POL : ~HS_POL;
      vs          <= tail.vs ? VS_POL : ~VS_POL;
      de          <= tail.de;
      frame_start <= tail.fs;
      {r, g, b}   <= (tail.de && tail.win) ? pix_rgb : '0;
    end
  end

endmodule

// File: tb/tb_vga_scanout_core.sv
// Bench for vga_scanout_core on a reduced raster: random image, mid-frame and
// random resets, optional palette writes; outputs compared to a position model.
module tb_vga_scanout_core;

  localparam int H_VIS = 40, H_FP = 4, H_SYNC = 6, H_BP = 6;
  localparam int V_VIS = 30, V_FP = 2, V_SYNC = 3, V_BP = 5;
  localparam bit HS_POL = 1'b0, VS_POL = 1'b1;
  localparam int IMG_W = 10, IMG_H = 7, SCALE = 3, MEM_LAT = 2;
  localparam int PIX_W = 4, ADDR_W = 8;
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int WIN_W = IMG_W * SCALE, WIN_H = IMG_H * SCALE;
  localparam int X0 = (H_VIS - WIN_W) / 2, Y0 = (V_VIS - WIN_H) / 2;
  localparam int NPIX = IMG_W * IMG_H;
  localparam int LAT = MEM_LAT + 1;

  // clock / reset
  logic pclk = 1'b0;
  logic rst  = 1'b1;
  always #5 pclk = ~pclk;

  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_data;
  logic [9:0]        h, v;
  logic              hs, vs, de, frame_start;
  logic [3:0]        r, g, b;
`ifdef VGA_SCANOUT_PALETTE_EN
  logic              pal_we  = 1'b0;
  logic [3:0]        pal_idx = '0;
  logic [11:0]       pal_rgb = '0;
`endif

  vga_scanout_core #(
    .H_VIS (H_VIS), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_VIS (V_VIS), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .HS_POL (HS_POL), .VS_POL (VS_POL),
    .IMG_W (IMG_W), .IMG_H (IMG_H), .SCALE (SCALE), .MEM_LAT (MEM_LAT),
    .PIX_W (PIX_W), .ADDR_W (ADDR_W)
  ) dut (
    .pclk        (pclk),
    .rst         (rst),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .h           (h),
    .v           (v),
    .hs          (hs),
    .vs          (vs),
    .de          (de),
    .r           (r),
    .g           (g),
    .b           (b),
    .frame_start (frame_start)
`ifdef VGA_SCANOUT_PALETTE_EN
    ,
    .pal_we      (pal_we),
    .pal_idx     (pal_idx),
    .pal_rgb     (pal_rgb)
`endif
  );

  // image memory with MEM_LAT read latency
  logic [PIX_W-1:0]  img    [NPIX];
  logic [ADDR_W-1:0] a_hist [MEM_LAT];
  always @(posedge pclk) begin
    a_hist[0] <= mem_addr;
    for (int i = 1; i < MEM_LAT; i++) a_hist[i] <= a_hist[i-1];
  end
  assign mem_data = img[a_hist[MEM_LAT-1]];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // model: screen position is a pure function of cycles since reset
  function automatic int xo(input int n); return n % H_TOT; endfunction
  function automatic int yo(input int n); return (n / H_TOT) % V_TOT; endfunction
  function automatic bit in_win(input int x, input int y);
    return x >= X0 && x < X0 + WIN_W && y >= Y0 && y < Y0 + WIN_H;
  endfunction
  function automatic int addr_of(input int x, input int y);
    return ((y - Y0) / SCALE) * IMG_W + (x - X0) / SCALE;
  endfunction

  int                c       = 0;
  bit                started = 1'b0;
  logic [ADDR_W-1:0] held    = '0;
`ifdef VGA_SCANOUT_PALETTE_EN
  logic [11:0] pal_cur [16];
  logic [11:0] pal_prev [16];
`endif

  always @(posedge pclk) begin
`ifdef VGA_SCANOUT_PALETTE_EN
    for (int i = 0; i < 16; i++) pal_prev[i] <= pal_cur[i];
`endif
    if (rst) begin
      c       <= 0;
      held    <= '0;
      started <= 1'b1;
`ifdef VGA_SCANOUT_PALETTE_EN
      for (int i = 0; i < 16; i++) pal_cur[i] <= 12'(i * 12'h111);
`endif
    end else begin
      if (in_win(xo(c), yo(c))) held <= ADDR_W'(addr_of(xo(c), yo(c)));
      c <= c + 1;
`ifdef VGA_SCANOUT_PALETTE_EN
      if (pal_we) pal_cur[pal_idx] <= pal_rgb;
`endif
    end
  end

  function automatic int colour_of(input int d);
`ifdef VGA_SCANOUT_PALETTE_EN
    return int'(pal_prev[d]);
`else
    return (d << 8) | (d << 4) | d;
`endif
  endfunction

  // compare process, mid-cycle
  int abs_cyc = 0, last_fs = 0, de_cnt = 0;
  bit fs_valid = 1'b0;

  always @(negedge pclk) begin
    abs_cyc++;
    if (rst) fs_valid = 1'b0;
    if (started) begin
      int x, y, k, px, py, ea;
      x  = xo(c);
      y  = yo(c);
      ea = in_win(x, y) ? addr_of(x, y) : int'(held);
      chk("h", int'(h), x);
      chk("v", int'(v), y);
      chk("mem_addr", int'(mem_addr), ea);
      if (x == X0 && y == Y0) chk("first_addr", int'(mem_addr), 0);
      if (x == X0 + WIN_W - 1 && y == Y0 + WIN_H - 1) chk("last_addr", int'(mem_addr), 69);
      if (c < LAT) begin
        chk("hs_rst", int'(hs), int'(!HS_POL));
        chk("vs_rst", int'(vs), int'(!VS_POL));
        chk("de_rst", int'(de), 0);
        chk("rgb_rst", int'({r, g, b}), 0);
        chk("fs_rst", int'(frame_start), 0);
      end else begin
        bit sh, sv, w;
        k  = c - LAT;
        px = xo(k);
        py = yo(k);
        sh = px >= H_VIS + H_FP && px < H_VIS + H_FP + H_SYNC;
        sv = py >= V_VIS + V_FP && py < V_VIS + V_FP + V_SYNC;
        w  = in_win(px, py);
        chk("hs", int'(hs), int'(sh ? HS_POL : !HS_POL));
        chk("vs", int'(vs), int'(sv ? VS_POL : !VS_POL));
        chk("de", int'(de), int'(px < H_VIS && py < V_VIS));
        chk("rgb", int'({r, g, b}), w ? colour_of(int'(img[addr_of(px, py)])) : 0);
        chk("frame_start", int'(frame_start), int'(px == 0 && py == 0));
      end
      if (frame_start) begin
        if (fs_valid) begin
          chk("fs_period", abs_cyc - last_fs, 2240);
          chk("de_per_frame", de_cnt, 1200);
        end
        last_fs  = abs_cyc;
        de_cnt   = 0;
        fs_valid = 1'b1;
      end
      if (de) de_cnt++;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge pclk);
    #2;
  endtask

  task automatic pulse_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

`ifdef VGA_SCANOUT_PALETTE_EN
  task automatic pal_write(input logic [3:0] idx, input logic [11:0] rgb);
    pal_we  = 1'b1;
    pal_idx = idx;
    pal_rgb = rgb;
    tick();
    pal_we  = 1'b0;
  endtask
`endif

  initial begin
    bit found;
    for (int i = 0; i < NPIX; i++) img[i] = PIX_W'($urandom_range(0, 15));
    img[0]  = 4'd5;
    img[35] = 4'd5;

    // pin the model against hand-computed positions
    chk("model_addr_first", addr_of(5, 4), 0);
    chk("model_addr_last", addr_of(34, 24), 69);
    chk("model_addr_col", addr_of(8, 6), 1);
    chk("model_addr_row", addr_of(7, 7), 10);
    chk("model_win_left", int'(in_win(4, 10)), 0);
    chk("model_win_right", int'(in_win(35, 10)), 0);

    repeat (3) tick();
    rst = 1'b0;
    repeat (2 * FRAME + 100) tick();

    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      tick();
      if (h == 10'd30 && v == 10'd20) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_reset_wait: got timeout expected h=30 v=20");
    end
    pulse_reset(3);
    repeat (FRAME + 50) tick();

`ifdef VGA_SCANOUT_PALETTE_EN
    pal_write(4'd5, 12'hF00);
    repeat ($urandom_range(100, 900)) tick();
    for (int i = 0; i < 6; i++) begin
      pal_write(4'($urandom_range(0, 15)), 12'($urandom_range(0, 4095)));
      repeat ($urandom_range(0, 40)) tick();
    end
    repeat (FRAME) tick();
`endif

    for (int n = 0; n < 3; n++) begin
      repeat ($urandom_range(50, FRAME)) tick();
      pulse_reset($urandom_range(1, 4));
    end
    repeat (FRAME + 200) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
